// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run-rate controller for the MIPS core.
// Issues a registered one-cycle cpu_en pulse in pause, slow, fast or single-step mode.
// Divider changes take effect only on a period boundary. Halt requests from the core are honoured.
`timescale 1ns/1ps
module cpu_clk_ctrl #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned DIV_FAST   = 4,
    parameter int unsigned DIV_SLOW   = 1000000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        resume,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [31:0] en_count
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StRun      = 2'b01,
        StStepWait = 2'b10,
        StHalted   = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DivFast = CNT_W'(DIV_FAST);
    localparam logic [CNT_W-1:0] DivSlow = CNT_W'(DIV_SLOW);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [7:0]       DebLast = 8'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             filt_q;
    logic             step_pulse_q;
    logic [7:0]       deb_cnt_q;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             cpu_en_q;
    logic [31:0]      en_count_q;
    logic             boundary;
    logic             run_mode;

    // Divider selected by a run mode (only called with 01 or 10)
    function automatic logic [CNT_W-1:0] div_for(input logic [1:0] m);
        return (m == 2'b01) ? DivSlow : DivFast;
    endfunction

    assign boundary = (cnt_q == (div_q - CntOne));
    assign run_mode = (mode == 2'b01) || (mode == 2'b10);

    // Synchronise and debounce step_btn; emit one pulse per accepted rising level
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            filt_q       <= 1'b0;
            deb_cnt_q    <= 8'd0;
            step_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= step_btn;
            sync2_q      <= sync1_q;
            step_pulse_q <= 1'b0;
            if (sync2_q != filt_q) begin
                if (deb_cnt_q == DebLast) begin
                    filt_q       <= sync2_q;
                    deb_cnt_q    <= 8'd0;
                    step_pulse_q <= sync2_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 8'd1;
                end
            end else begin
                deb_cnt_q <= 8'd0;
            end
        end
    end

    // Run-rate FSM with period counter and registered enable/count outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= DivFast;
            cpu_en_q   <= 1'b0;
            en_count_q <= 32'd0;
        end else begin
            cpu_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (run_mode) div_q <= div_for(mode);
                    if (halt_req)           state_q <= StHalted;
                    else if (run_mode)      state_q <= StRun;
                    else if (mode == 2'b11) state_q <= StStepWait;
                end
                StRun: begin
                    if (halt_req) begin
                        cnt_q   <= '0;
                        state_q <= StHalted;
                    end else if (boundary) begin
                        cnt_q      <= '0;
                        cpu_en_q   <= 1'b1;
                        en_count_q <= en_count_q + 32'd1;
                        if (run_mode)           div_q   <= div_for(mode);
                        if (mode == 2'b00)      state_q <= StIdle;
                        else if (mode == 2'b11) state_q <= StStepWait;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StStepWait: begin
                    cnt_q <= '0;
                    if (halt_req) begin
                        state_q <= StHalted;
                    end else begin
                        // A step right after a boundary pulse is dropped so cpu_en never
                        // stays high on two consecutive cycles.
                        if (step_pulse_q && !cpu_en_q) begin
                            cpu_en_q   <= 1'b1;
                            en_count_q <= en_count_q + 32'd1;
                        end
                        if (mode != 2'b11) state_q <= StIdle;
                    end
                end
                StHalted: begin
                    cnt_q <= '0;
                    if (resume && !halt_req) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_en   = cpu_en_q;
    assign state    = state_q;
    assign en_count = en_count_q;

endmodule
